// File: rtl/hough_pkg.sv
// rtl/hough_pkg.sv - shared frame parameters, types, FSM encoding and Q1.10 trig tables for the lane overlay
package hough_pkg;

  localparam int          WIDTH       = 1280;
  localparam int          HEIGHT      = 720;
  localparam int          THETA_BITS  = 9;
  localparam int          TRIG_FRAC   = 10;
  localparam int          LINE_TOL    = 2;
  localparam logic [23:0] LINE_COLOR  = 24'h0000FF;
  localparam int          THETA_RANGE = 180;

  typedef logic signed [11:0] trig_t;
  typedef logic signed [15:0] rho_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // round(1024*cos(k deg)), k = 0..90; the 180-entry cos/sin tables fold onto this quadrant
  localparam int QCOS [0:90] = '{
    1024, 1024, 1023, 1023, 1022, 1020, 1018, 1016, 1014, 1011,
    1008, 1005, 1002,  998,  994,  989,  984,  979,  974,  968,
     962,  956,  949,  943,  935,  928,  920,  912,  904,  896,
     887,  878,  868,  859,  849,  839,  828,  818,  807,  796,
     784,  773,  761,  749,  737,  724,  711,  698,  685,  672,
     658,  644,  630,  616,  602,  587,  573,  558,  543,  527,
     512,  496,  481,  465,  449,  433,  416,  400,  384,  367,
     350,  333,  316,  299,  282,  265,  248,  230,  213,  195,
     178,  160,  143,  125,  107,   89,   71,   54,   36,   18,
       0
  };

  function automatic trig_t trig_cos(input logic [7:0] t);
    if (t <= 8'd90) return trig_t'(QCOS[t[6:0]]);
    return trig_t'(-QCOS[7'(8'd180 - t)]);
  endfunction

  function automatic trig_t trig_sin(input logic [7:0] t);
    if (t <= 8'd90) return trig_t'(QCOS[7'(8'd90 - t)]);
    return trig_t'(QCOS[7'(t - 8'd90)]);
  endfunction

endpackage

// File: rtl/hough_line_overlay_trig_rom.sv
// rtl/hough_line_overlay_trig_rom.sv - hough_trig_rom: dual-read registered theta -> {cos,sin} ROM, 1-cycle latency
module hough_trig_rom
  import hough_pkg::*;
#(
  parameter int THETA_BITS = hough_pkg::THETA_BITS
) (
  input  logic                  clock,
  input  logic [THETA_BITS-1:0] theta_a,
  input  logic [THETA_BITS-1:0] theta_b,
  output trig_t                 cos_a,
  output trig_t                 sin_a,
  output trig_t                 cos_b,
  output trig_t                 sin_b
);

  // Out-of-range theta reads as zero; the top also masks those lines off.
  always_ff @(posedge clock) begin
    if (theta_a < THETA_BITS'(THETA_RANGE)) begin
      cos_a <= trig_cos(theta_a[7:0]);
      sin_a <= trig_sin(theta_a[7:0]);
    end else begin
      cos_a <= '0;
      sin_a <= '0;
    end
    if (theta_b < THETA_BITS'(THETA_RANGE)) begin
      cos_b <= trig_cos(theta_b[7:0]);
      sin_b <= trig_sin(theta_b[7:0]);
    end else begin
      cos_b <= '0;
      sin_b <= '0;
    end
  end

endmodule

// File: rtl/hough_line_overlay.sv
// rtl/hough_line_overlay.sv - re-streams a frame and paints the left/right Hough lines into it
// Optional feature macro: ROI_CLIP_EN (accept hits only in the lower half of the frame).
module hough_line_overlay
  import hough_pkg::*;
#(
  parameter int          WIDTH      = hough_pkg::WIDTH,
  parameter int          HEIGHT     = hough_pkg::HEIGHT,
  parameter int          THETA_BITS = hough_pkg::THETA_BITS,
  parameter int          LINE_TOL   = hough_pkg::LINE_TOL,
  parameter logic [23:0] LINE_COLOR = hough_pkg::LINE_COLOR
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [15:0]    left_rho,
  input  logic [THETA_BITS-1:0] left_theta,
  input  logic signed [15:0]    right_rho,
  input  logic [THETA_BITS-1:0] right_theta,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic [23:0]           in_dout,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [23:0]           out_din,
  output logic                  done
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam logic [CW-1:0]      TOTAL_C = CW'(TOTAL);
  localparam logic [CW-1:0]      LAST_C  = CW'(TOTAL - 1);
  localparam logic [XW-1:0]      X_LAST  = XW'(WIDTH - 1);
  localparam logic signed [16:0] TOL     = 17'(LINE_TOL);

  state_t state, state_nx;
  logic start_ok, advance, pop, push;
  logic [CW-1:0] pops, pushes;
  logic [XW-1:0] x_cnt, x1;
  logic [YW-1:0] y_cnt, y1;
  rho_t l_rho, r_rho;
  logic [THETA_BITS-1:0] l_theta, r_theta;
  trig_t l_cos, l_sin, r_cos, r_sin;
  logic v1, v2, v3;
  logic [23:0] px1, px2;
  logic signed [23:0] l_xc, l_ys, r_xc, r_ys, l_sum, r_sum;
  logic signed [16:0] l_diff, r_diff;
  logic l_en, r_en, l_hit, r_hit, roi_ok;

  assign start_ok = start && (state != S_STREAM);
  assign advance  = !out_full || !v3;
  assign pop      = in_rd_en;
  assign push     = out_wr_en;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_STREAM;
      S_STREAM:       if (push && (pushes == LAST_C)) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    done      = 1'b0;
    if (!reset) begin
      out_wr_en = v3 && !out_full;
      case (state)
        S_STREAM: in_rd_en = !in_empty && advance && (pops < TOTAL_C);
        S_DONE:   done = 1'b1;
        default:  ;
      endcase
    end
  end

  // Line parameters are frozen for the whole frame; the ROM re-reads the same address every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      l_rho   <= '0;
      r_rho   <= '0;
      l_theta <= '1;
      r_theta <= '1;
    end else if (start_ok) begin
      l_rho   <= left_rho;
      r_rho   <= right_rho;
      l_theta <= left_theta;
      r_theta <= right_theta;
    end
  end

  hough_trig_rom #(.THETA_BITS(THETA_BITS)) u_trig_rom (
    .clock   (clock),
    .theta_a (l_theta),
    .theta_b (r_theta),
    .cos_a   (l_cos),
    .sin_a   (l_sin),
    .cos_b   (r_cos),
    .sin_b   (r_sin)
  );

  assign l_en = l_theta < THETA_BITS'(THETA_RANGE);
  assign r_en = r_theta < THETA_BITS'(THETA_RANGE);

  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      pops   <= '0;
      pushes <= '0;
    end else begin
      if (pop) begin
        pops <= pops + 1'b1;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
      if (push) pushes <= pushes + 1'b1;
    end
  end

  // The whole pipeline moves as one; it only holds when a finished pixel cannot be pushed.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      out_din <= '0;
    end else if (advance) begin
      v1      <= pop;
      v2      <= v1;
      v3      <= v2;
      out_din <= (roi_ok && (l_hit || r_hit)) ? LINE_COLOR : px2;
    end
  end

  always_ff @(posedge clock) begin
    if (advance) begin
      px1  <= in_dout;
      x1   <= x_cnt;
      y1   <= y_cnt;
      px2  <= px1;
      l_xc <= 24'($signed({1'b0, x1})) * 24'(l_cos);
      l_ys <= 24'($signed({1'b0, y1})) * 24'(l_sin);
      r_xc <= 24'($signed({1'b0, x1})) * 24'(r_cos);
      r_ys <= 24'($signed({1'b0, y1})) * 24'(r_sin);
    end
  end

`ifdef ROI_CLIP_EN
  logic [YW-1:0] y2;
  always_ff @(posedge clock) begin
    if (advance) y2 <= y1;
  end
  assign roi_ok = (y2 >= YW'(HEIGHT / 2));
`else
  assign roi_ok = 1'b1;
`endif

  always_comb begin
    l_sum  = l_xc + l_ys;
    r_sum  = r_xc + r_ys;
    l_diff = 17'(l_sum >>> TRIG_FRAC) - 17'(l_rho);
    r_diff = 17'(r_sum >>> TRIG_FRAC) - 17'(r_rho);
    l_hit  = l_en && (l_diff >= -TOL) && (l_diff <= TOL);
    r_hit  = r_en && (r_diff >= -TOL) && (r_diff <= TOL);
  end

endmodule

// File: tb/tb_hough_line_overlay.sv
// tb/tb_hough_line_overlay.sv - randomized self-checking bench for hough_line_overlay on a reduced frame
`timescale 1ns/1ps
module tb_hough_line_overlay;

  localparam int          W     = 32;
  localparam int          H     = 128;
  localparam int          N     = W * H;
  localparam logic [23:0] COLOR = 24'h0000FF;
  localparam real         PI    = 3.14159265358979323846;

  logic               clock = 1'b0;
  logic               reset, start;
  logic signed [15:0] left_rho, right_rho;
  logic [8:0]         left_theta, right_theta;
  logic               in_empty, in_rd_en, out_full, out_wr_en, done;
  logic [23:0]        in_dout, out_din;

  hough_line_overlay #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .left_rho    (left_rho),
    .left_theta  (left_theta),
    .right_rho   (right_rho),
    .right_theta (right_theta),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .in_dout     (in_dout),
    .out_full    (out_full),
    .out_wr_en   (out_wr_en),
    .out_din     (out_din),
    .done        (done)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] pix [N];
  logic [23:0] got [$];
  logic [23:0] ref_run [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int trig(input int t, input bit is_sin);
    real r;
    r = (is_sin ? $sin(t * PI / 180.0) : $cos(t * PI / 180.0)) * 1024.0;
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic int fdiv1024(input int s);
    return (s >= 0) ? s / 1024 : -((1023 - s) / 1024);
  endfunction

  function automatic bit on_line(input int x, input int y, input int theta, input int rho);
    int rc;
    if (theta >= 180) return 1'b0;
    rc = fdiv1024(x * trig(theta, 1'b0) + y * trig(theta, 1'b1));
    return (rc - rho <= 2) && (rho - rc <= 2);
  endfunction

  function automatic logic [23:0] expect_px(input int i, input int lt, input int lr, input int rt, input int rr);
    int x, y;
    x = i % W;
    y = i / W;
`ifdef ROI_CLIP_EN
    if (y < H / 2) return pix[i];
`endif
    return (on_line(x, y, lt, lr) || on_line(x, y, rt, rr)) ? COLOR : pix[i];
  endfunction

  task automatic fill_pixels();
    for (int i = 0; i < N; i++) begin
      pix[i] = 24'($urandom);
      if (pix[i] == COLOR) pix[i] = pix[i] ^ 24'h800000;
    end
  endtask

  task automatic run_frame(input string tag, input int lt, input int lr, input int rt, input int rr,
                           input bit stall, input int abort_at, input int restart_at, output int colored);
    int ptr, cyc, burst, done_early, full_push, mism;
    bit last_seen;
    ptr = 0; cyc = 0; burst = 0; done_early = 0; full_push = 0; mism = 0; last_seen = 1'b0; colored = 0;
    got.delete();
    start = 1'b1;
    left_theta = 9'(lt); left_rho = 16'(lr); right_theta = 9'(rt); right_rho = 16'(rr);
    in_empty = 1'b1; out_full = 1'b0;
    @(posedge clock); #1;
    while (!last_seen && cyc < 6 * N) begin
      left_rho = 16'($urandom); left_theta = 9'($urandom);
      right_rho = 16'($urandom); right_theta = 9'($urandom);
      start = (cyc == restart_at);
      if (stall) begin
        out_full = ($urandom_range(0, 1) == 1);
        if (burst > 0) begin
          in_empty = 1'b1;
          burst--;
        end else if ($urandom_range(0, 7) == 0) begin
          in_empty = 1'b1;
          burst = $urandom_range(1, 6);
        end else begin
          in_empty = 1'b0;
        end
      end else begin
        out_full = 1'b0;
        in_empty = 1'b0;
      end
      if (ptr >= N) in_empty = 1'b1;
      in_dout = (ptr < N) ? pix[ptr] : 24'($urandom);
      if (abort_at >= 0 && ptr >= abort_at) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0; in_empty = 1'b0; out_full = 1'b0;
        #1;
        chk({tag, "_rd_after_reset"}, in_rd_en, 0);
        chk({tag, "_wr_after_reset"}, out_wr_en, 0);
        chk({tag, "_done_after_reset"}, done, 0);
        return;
      end
      #1;
      if (done) done_early++;
      if (out_wr_en && out_full) full_push++;
      if (in_rd_en) ptr++;
      if (out_wr_en) begin
        got.push_back(out_din);
        if (got.size() == N) last_seen = 1'b1;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0; in_empty = 1'b0; out_full = 1'b0;
    #1;
    chk({tag, "_done_next"}, done, 1);
    chk({tag, "_push_count"}, got.size(), N);
    chk({tag, "_done_early"}, done_early, 0);
    chk({tag, "_push_while_full"}, full_push, 0);
    repeat (3) @(posedge clock);
    #1;
    chk({tag, "_done_hold"}, done, 1);
    chk({tag, "_no_pop_in_done"}, in_rd_en, 0);
    for (int i = 0; i < got.size(); i++) begin
      if (got[i] !== expect_px(i, lt, lr, rt, rr)) mism++;
      if (got[i] == COLOR) colored++;
    end
    chk({tag, "_model_mismatches"}, mism, 0);
  endtask

  initial begin
    int colored, diffs, t, rt, px, py, rr, lr;
    reset = 1'b1; start = 1'b0; in_empty = 1'b1; out_full = 1'b0; in_dout = '0;
    left_theta = '0; right_theta = '0; left_rho = '0; right_rho = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rd", in_rd_en, 0);
    chk("reset_wr", out_wr_en, 0);
    chk("reset_done", done, 0);
    chk("reset_dout", out_din, 0);
    reset = 1'b0; in_empty = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_no_pop", in_rd_en, 0);
    chk("idle_done", done, 0);

    fill_pixels();
    run_frame("row90", 90, 100, 511, 0, 1'b0, -1, -1, colored);
    chk("row90_colored", colored, 5 * W);
    ref_run = got;

    run_frame("row90_stall", 90, 100, 511, 0, 1'b1, -1, -1, colored);
    diffs = 0;
    for (int i = 0; i < N; i++)
      if (i >= got.size() || got[i] !== ref_run[i]) diffs++;
    chk("stall_vs_unstalled", diffs, 0);

    fill_pixels();
    run_frame("col0", 0, 16, 0, 16, 1'b0, -1, -1, colored);
`ifdef ROI_CLIP_EN
    chk("col0_colored", colored, 5 * H / 2);
`else
    chk("col0_colored", colored, 5 * H);
`endif

    run_frame("upper_row", 90, 30, 200, 0, 1'b0, -1, -1, colored);
`ifdef ROI_CLIP_EN
    chk("upper_row_colored", colored, 0);
`else
    chk("upper_row_colored", colored, 5 * W);
`endif

    for (int k = 0; k < 2; k++) begin
      fill_pixels();
      t  = $urandom_range(0, 179);
      px = $urandom_range(0, W - 1);
      py = $urandom_range(0, H - 1);
      lr = fdiv1024(px * trig(t, 1'b0) + py * trig(t, 1'b1));
      rt = ($urandom_range(0, 2) == 0) ? $urandom_range(180, 511) : $urandom_range(0, 179);
      px = $urandom_range(0, W - 1);
      py = $urandom_range(0, H - 1);
      rr = (rt < 180) ? fdiv1024(px * trig(rt, 1'b0) + py * trig(rt, 1'b1)) : 0;
      run_frame("random", t, lr, rt, rr, 1'b1, -1, -1, colored);
    end

    run_frame("restart_ignored", 45, 60, 135, -10, 1'b0, -1, 500, colored);

    run_frame("abort", 90, 100, 511, 0, 1'b0, 1000, -1, colored);
    run_frame("after_abort", 90, 100, 511, 0, 1'b0, -1, -1, colored);
    chk("after_abort_colored", colored, 5 * W);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
